seq_mult8: RTL

SEQ_MULT8 -- requirements
Module: seq_mult8

---
 rtl/seq_mult8.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seq_mult8.sv
// seq_mult8 -- 8x8 unsigned shift-add multiplier built around a single
// 8-bit ripple-carry adder (rca). One multiplier bit is consumed per RUN
// cycle; the 16-bit product appears on p when the operation completes.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   operation request, only looked at in IDLE
//   a      in   8   multiplicand (unsigned)
//   b      in   8   multiplier (unsigned)
//   busy   out  1   high while an operation is in RUN or DONE
//   done   out  1   one-cycle completion pulse
//   p      out 16   product, held until the next accepted start
//
// Build option:
//   SEQ_MULT8_EARLY_TERM_EN  when defined, the operation finishes as soon as
//                            the remaining multiplier bits are all zero by
//                            shifting out all remaining positions in one step.

module rca (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[8];
endmodule

// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands are latched on the accepting edge
// RUN   | one shift-add iteration per edge, 8 in total (fewer with
//       | early termination)
// DONE  | single cycle; done pulses, p already holds the product
module seq_mult8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // acc = {carry, hi, lo}; lo starts as the multiplier and is shifted out
  // while the partial product shifts in from hi.
  logic [16:0] acc;
  logic [7:0]  mcand;
  logic [3:0]  iter;
  logic [15:0] prod;

  logic [7:0]  sum;
  logic        cout;
  logic [16:0] acc_step;
  logic        step_last;

`ifdef SEQ_MULT8_EARLY_TERM_EN
  logic [7:0]  rem_mask;
`endif

  rca u_rca (
    .x    (acc[15:8]),
    .y    (mcand),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    step_last = (iter == 4'd7);
    if (acc[0]) begin
      acc_step = {cout, sum, acc[7:0]} >> 1;
    end else begin
      acc_step = acc >> 1;
    end
`ifdef SEQ_MULT8_EARLY_TERM_EN
    // The low (8 - iter) bits of lo are the multiplier bits not yet used.
    // If none is set, no further add can happen: finish the shifts at once.
    rem_mask = 8'hFF >> iter;
    if ((acc[7:0] & rem_mask) == 8'h00) begin
      acc_step  = acc >> (4'd8 - iter);
      step_last = 1'b1;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (step_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath; prod only loads on the edge entering DONE so p is stable
  // throughout RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      iter  <= '0;
      prod  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {1'b0, 8'h00, b};
            iter  <= '0;
          end
        end
        S_RUN: begin
          acc  <= acc_step;
          iter <= iter + 4'd1;
          if (step_last) prod <= acc_step[15:0];
        end
        default: ;
      endcase
    end
  end

  assign p = prod;
endmodule
